pc_fetch: RTL and testbench

Program-counter register and instruction-fetch sequencer for the single-cycle MIPS core. It holds the current PC and drives it to the next-PC logic. It fetches the instruction at that PC from instruction memory over a request/grant/response handshake, then presents the instruction to decode. On retire, it loads the next-PC value computed for the current instruction.

---
 rtl/pc_fetch.sv | 111 +++++++++++
 tb/tb_pc_fetch.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch.sv
// PC register and single-outstanding instruction-fetch sequencer (REQ -> WAIT -> HOLD).
// Optional feature macro: PC_ALIGN_CHECK_EN (misaligned retire target traps into ERR).
module pc_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] pc_out,
    input  logic [31:0] new_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    output logic [31:0] retire_cnt,
    output logic        align_err
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
`ifdef PC_ALIGN_CHECK_EN
        ,S_ERR = 2'd3
`endif
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_retire_cnt;
    logic        w_retire;
    logic [31:0] w_pc_nxt;

    assign w_retire = (r_state == S_HOLD) && instr_ready;

`ifdef PC_ALIGN_CHECK_EN
    logic r_align_err;
    logic w_misaligned;

    // Faulting target is loaded unmodified so it shows up on pc_out.
    assign w_misaligned = (new_pc[1:0] != 2'b00);
    assign w_pc_nxt     = new_pc;
    assign align_err    = r_align_err;
`else
    assign w_pc_nxt     = new_pc & ~32'h0000_0003;
    assign align_err    = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_REQ:  if (imem_gnt)    w_state_nxt = S_WAIT;
            S_WAIT: if (imem_rvalid) w_state_nxt = S_HOLD;
            S_HOLD: begin
                if (instr_ready) begin
`ifdef PC_ALIGN_CHECK_EN
                    w_state_nxt = w_misaligned ? S_ERR : S_REQ;
`else
                    w_state_nxt = S_REQ;
`endif
                end
            end
`ifdef PC_ALIGN_CHECK_EN
            S_ERR:  w_state_nxt = S_ERR;
`endif
            default: w_state_nxt = S_REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_REQ;
            r_pc         <= RESET_PC;
            r_instr      <= 32'h0;
            r_retire_cnt <= 32'h0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == S_WAIT) && imem_rvalid)
                r_instr <= imem_rdata;
            if (w_retire) begin
                r_pc         <= w_pc_nxt;
                r_retire_cnt <= r_retire_cnt + 32'd1;
            end
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset)
            r_align_err <= 1'b0;
        else if (w_retire && w_misaligned)
            r_align_err <= 1'b1;
    end
`endif

    // Outputs decode from registers only; no input-to-output paths.
    assign pc_out      = r_pc;
    assign imem_req    = (r_state == S_REQ);
    assign imem_addr   = r_pc;
    assign instr_valid = (r_state == S_HOLD);
    assign instr       = r_instr;
    assign instr_pc    = r_pc;
    assign retire_cnt  = r_retire_cnt;

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: directed vector table, reset/misalignment
// sequences and randomized fetch handshakes against a transaction-level model.
module tb_pc_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_out, new_pc, imem_addr, imem_rdata, instr, instr_pc, retire_cnt;
    logic        imem_req, imem_gnt, imem_rvalid, instr_valid, instr_ready, align_err;

    pc_fetch #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .reset(reset), .pc_out(pc_out), .new_pc(new_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_ready(instr_ready), .retire_cnt(retire_cnt), .align_err(align_err)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // Reference model: architectural PC and retire count.
    logic [31:0] m_pc;
    logic [31:0] m_cnt;

    typedef struct {
        int unsigned gd;
        int unsigned rd;
        int unsigned hd;
        logic [31:0] rdata;
        logic [31:0] np;
        logic [31:0] exp_next;
    } vec_t;

    vec_t tbl[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        instr_ready = 1'b0; new_pc = 32'h0;
        step();
        step();
        reset = 1'b0;
        m_pc = RST_PC;
        m_cnt = 32'h0;
    endtask

    // One full instruction: gd REQ stalls, rd WAIT stalls, hd HOLD stalls, then retire.
    task automatic txn(input int unsigned gd, input int unsigned rd, input int unsigned hd,
                       input logic [31:0] data, input logic [31:0] np);
        chk("req_start", {31'h0, imem_req}, 32'h1);
        chk("addr_start", imem_addr, m_pc);
        chk("valid_in_req", {31'h0, instr_valid}, 32'h0);
        for (int i = 0; i < int'(gd); i++) begin
            imem_gnt = 1'b0;
            imem_rvalid = 1'($urandom);
            imem_rdata = $urandom;
            instr_ready = 1'($urandom);
            new_pc = $urandom;
            step();
            chk("req_stall_req", {31'h0, imem_req}, 32'h1);
            chk("req_stall_addr", imem_addr, m_pc);
        end
        imem_gnt = 1'b1; imem_rvalid = 1'b0; instr_ready = 1'($urandom);
        step();
        imem_gnt = 1'b0;
        chk("wait_req", {31'h0, imem_req}, 32'h0);
        chk("wait_valid", {31'h0, instr_valid}, 32'h0);
        for (int i = 0; i < int'(rd); i++) begin
            imem_rvalid = 1'b0;
            imem_rdata = $urandom;
            instr_ready = 1'($urandom);
            new_pc = $urandom;
            step();
            chk("wait_stall_pc", pc_out, m_pc);
            chk("wait_stall_valid", {31'h0, instr_valid}, 32'h0);
        end
        imem_rvalid = 1'b1; imem_rdata = data; instr_ready = 1'b0;
        step();
        imem_rvalid = 1'b0; imem_rdata = $urandom;
        chk("hold_valid", {31'h0, instr_valid}, 32'h1);
        chk("hold_instr", instr, data);
        chk("hold_instr_pc", instr_pc, m_pc);
        for (int i = 0; i < int'(hd); i++) begin
            instr_ready = 1'b0;
            new_pc = $urandom;
            imem_rvalid = 1'($urandom);
            imem_rdata = $urandom;
            step();
            chk("hold_stall_pc", pc_out, m_pc);
            chk("hold_stall_instr", instr, data);
            chk("hold_stall_valid", {31'h0, instr_valid}, 32'h1);
        end
        imem_rvalid = 1'b0;
        instr_ready = 1'b1; new_pc = np;
        step();
        instr_ready = 1'b0; new_pc = $urandom;
        m_cnt = m_cnt + 1;
`ifdef PC_ALIGN_CHECK_EN
        m_pc = np;
`else
        m_pc = {np[31:2], 2'b00};
`endif
        chk("retire_cnt", retire_cnt, m_cnt);
        chk("retire_pc", pc_out, m_pc);
    endtask

    initial begin
        tbl[0] = '{gd: 0, rd: 0, hd: 0, rdata: 32'h2408_0005, np: 32'h0000_3004, exp_next: 32'h0000_3004};
        tbl[1] = '{gd: 3, rd: 4, hd: 0, rdata: 32'h8C09_0000, np: 32'h0000_3008, exp_next: 32'h0000_3008};
        tbl[2] = '{gd: 0, rd: 0, hd: 5, rdata: 32'h0109_5020, np: 32'h0000_3010, exp_next: 32'h0000_3010};
        tbl[3] = '{gd: 1, rd: 1, hd: 1, rdata: 32'h0810_0004, np: 32'h0040_0010, exp_next: 32'h0040_0010};

        do_reset();
        chk("rst_pc", pc_out, 32'h0000_3000);
        chk("rst_instr", instr, 32'h0);
        chk("rst_valid", {31'h0, instr_valid}, 32'h0);
        chk("rst_cnt", retire_cnt, 32'h0);
        chk("rst_align", {31'h0, align_err}, 32'h0);
        chk("rst_req", {31'h0, imem_req}, 32'h1);
        chk("first_addr", imem_addr, 32'h0000_3000);

        for (int i = 0; i < 4; i++) begin
            txn(tbl[i].gd, tbl[i].rd, tbl[i].hd, tbl[i].rdata, tbl[i].np);
            chk("tbl_next_addr", imem_addr, tbl[i].exp_next);
            chk("tbl_next_req", {31'h0, imem_req}, 32'h1);
        end
        chk("tbl_cnt", retire_cnt, 32'd4);

        // Reset while a response is pending in WAIT.
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        chk("pre_rst_wait_req", {31'h0, imem_req}, 32'h0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        m_pc = RST_PC; m_cnt = 32'h0;
        chk("wrst_pc", pc_out, RST_PC);
        chk("wrst_valid", {31'h0, instr_valid}, 32'h0);
        chk("wrst_cnt", retire_cnt, 32'h0);
        chk("wrst_req", {31'h0, imem_req}, 32'h1);

        // Randomized instructions against the model.
        for (int i = 0; i < 40; i++) begin
            logic [31:0] np;
            np = $urandom;
`ifdef PC_ALIGN_CHECK_EN
            np[1:0] = 2'b00;
`endif
            txn($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom, np);
        end

        // Misaligned retire target.
        do_reset();
        txn(0, 0, 0, 32'h2408_0005, 32'h0000_3006);
`ifdef PC_ALIGN_CHECK_EN
        for (int i = 0; i < 3; i++) begin
            imem_gnt = 1'b1; imem_rvalid = 1'b1; instr_ready = 1'b1;
            chk("err_align", {31'h0, align_err}, 32'h1);
            chk("err_pc", pc_out, 32'h0000_3006);
            chk("err_req", {31'h0, imem_req}, 32'h0);
            chk("err_valid", {31'h0, instr_valid}, 32'h0);
            step();
        end
        chk("err_cnt", retire_cnt, 32'h1);
`else
        chk("mask_addr", imem_addr, 32'h0000_3004);
        chk("mask_req", {31'h0, imem_req}, 32'h1);
        chk("mask_align", {31'h0, align_err}, 32'h0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
